// File: rtl/id_ex_stage_if.sv
// ID/EX pipeline stage signal bundle: decode-side inputs, MEM/WB feedback, and EX-side outputs.
// master drives the decode/feedback side; slave is the id_ex_stage register itself.
interface id_ex_stage_if #(parameter int B = 32);
  logic         id_valid;
  logic [B-1:0] id_rs_data;
  logic [B-1:0] id_rt_data;
  logic [B-1:0] id_imm;
  logic [4:0]   id_rs_addr;
  logic [4:0]   id_rt_addr;
  logic [4:0]   id_rd_addr;
  logic [3:0]   id_alu_control;
  logic         id_alu_src;
  logic         id_reg_dst;
  logic         id_reg_write;
  logic         id_mem_read;
  logic         id_mem_write;
  logic         id_mem_to_reg;

  logic         mem_reg_write;
  logic [4:0]   mem_write_addr;
  logic [B-1:0] mem_alu_result;
  logic         wb_reg_write;
  logic [4:0]   wb_write_addr;
  logic [B-1:0] wb_write_data;

  logic         flush;
  logic         stall;

  logic [B-1:0] ex_op1;
  logic [B-1:0] ex_op2;
  logic [3:0]   ex_alu_control;
  logic [B-1:0] ex_store_data;
  logic         ex_valid;
  logic         ex_reg_write;
  logic         ex_mem_read;
  logic         ex_mem_write;
  logic         ex_mem_to_reg;
  logic [4:0]   ex_write_addr;

  modport master (
    output id_valid, id_rs_data, id_rt_data, id_imm,
    output id_rs_addr, id_rt_addr, id_rd_addr,
    output id_alu_control, id_alu_src, id_reg_dst,
    output id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg,
    output mem_reg_write, mem_write_addr, mem_alu_result,
    output wb_reg_write, wb_write_addr, wb_write_data,
    output flush,
    input  stall,
    input  ex_op1, ex_op2, ex_alu_control, ex_store_data,
    input  ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg,
    input  ex_write_addr
  );

  modport slave (
    input  id_valid, id_rs_data, id_rt_data, id_imm,
    input  id_rs_addr, id_rt_addr, id_rd_addr,
    input  id_alu_control, id_alu_src, id_reg_dst,
    input  id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg,
    input  mem_reg_write, mem_write_addr, mem_alu_result,
    input  wb_reg_write, wb_write_addr, wb_write_data,
    input  flush,
    output stall,
    output ex_op1, ex_op2, ex_alu_control, ex_store_data,
    output ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg,
    output ex_write_addr
  );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with same-cycle WB bypass, load-use stall and bubble insertion.
// Define FORWARDING_EN for MEM/WB operand forwarding; otherwise RAW hazards stall until WB.
module id_ex_stage #(
  parameter int B = 32
) (
  input  logic      clk,
  input  logic      reset_n,
  id_ex_stage_if.slave bus
);

  logic [B-1:0] rs_val_r;
  logic [B-1:0] rt_val_r;
  logic [B-1:0] imm_r;
  logic         alu_src_r;
  logic [3:0]   alu_control_r;
  logic [4:0]   write_addr_r;
  logic         valid_r;
  logic         reg_write_r;
  logic         mem_read_r;
  logic         mem_write_r;
  logic         mem_to_reg_r;

  logic [B-1:0] rs_cap;
  logic [B-1:0] rt_cap;
  logic         load_use;
  logic         raw_stall;
  logic         stall_int;
  logic         bubble;
  logic [B-1:0] rs_fwd;
  logic [B-1:0] rt_fwd;

  // Register file writes land at the same edge we capture, so take WB data directly.
  always_comb begin
    rs_cap = bus.id_rs_data;
    rt_cap = bus.id_rt_data;
    if (bus.wb_reg_write && (bus.wb_write_addr != 5'd0) &&
        (bus.wb_write_addr == bus.id_rs_addr))
      rs_cap = bus.wb_write_data;
    if (bus.wb_reg_write && (bus.wb_write_addr != 5'd0) &&
        (bus.wb_write_addr == bus.id_rt_addr))
      rt_cap = bus.wb_write_data;
  end

  always_comb begin
    load_use = 1'b0;
    if (bus.id_valid && mem_read_r && (write_addr_r != 5'd0) &&
        ((write_addr_r == bus.id_rs_addr) || (write_addr_r == bus.id_rt_addr)))
      load_use = 1'b1;
  end

`ifdef FORWARDING_EN
  assign raw_stall = 1'b0;
`else
  // Without forwarding, any producer still in EX or MEM blocks the consumer.
  always_comb begin
    raw_stall = 1'b0;
    if (bus.id_valid) begin
      if ((bus.id_rs_addr != 5'd0) &&
          ((reg_write_r && (bus.id_rs_addr == write_addr_r)) ||
           (bus.mem_reg_write && (bus.id_rs_addr == bus.mem_write_addr))))
        raw_stall = 1'b1;
      if ((bus.id_rt_addr != 5'd0) &&
          ((reg_write_r && (bus.id_rt_addr == write_addr_r)) ||
           (bus.mem_reg_write && (bus.id_rt_addr == bus.mem_write_addr))))
        raw_stall = 1'b1;
    end
  end
`endif

  // Reset gating keeps stall low while the feedback inputs are still arbitrary.
  assign stall_int = reset_n && (load_use || raw_stall);
  assign bubble    = !bus.id_valid || bus.flush || stall_int;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rs_val_r      <= '0;
      rt_val_r      <= '0;
      imm_r         <= '0;
      alu_src_r     <= 1'b0;
      alu_control_r <= 4'd0;
      write_addr_r  <= 5'd0;
      valid_r       <= 1'b0;
      reg_write_r   <= 1'b0;
      mem_read_r    <= 1'b0;
      mem_write_r   <= 1'b0;
      mem_to_reg_r  <= 1'b0;
    end else begin
      rs_val_r      <= rs_cap;
      rt_val_r      <= rt_cap;
      imm_r         <= bus.id_imm;
      alu_src_r     <= bus.id_alu_src;
      alu_control_r <= bus.id_alu_control;
      write_addr_r  <= bus.id_reg_dst ? bus.id_rd_addr : bus.id_rt_addr;
      valid_r       <= !bubble;
      reg_write_r   <= !bubble && bus.id_reg_write;
      mem_read_r    <= !bubble && bus.id_mem_read;
      mem_write_r   <= !bubble && bus.id_mem_write;
      mem_to_reg_r  <= !bubble && bus.id_mem_to_reg;
    end
  end

`ifdef FORWARDING_EN
  logic [4:0] rs_addr_r;
  logic [4:0] rt_addr_r;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rs_addr_r <= 5'd0;
      rt_addr_r <= 5'd0;
    end else begin
      rs_addr_r <= bus.id_rs_addr;
      rt_addr_r <= bus.id_rt_addr;
    end
  end

  // MEM is the younger producer, so it wins over WB; $0 is never forwarded.
  always_comb begin
    rs_fwd = rs_val_r;
    if (bus.mem_reg_write && (bus.mem_write_addr != 5'd0) &&
        (bus.mem_write_addr == rs_addr_r))
      rs_fwd = bus.mem_alu_result;
    else if (bus.wb_reg_write && (bus.wb_write_addr != 5'd0) &&
             (bus.wb_write_addr == rs_addr_r))
      rs_fwd = bus.wb_write_data;

    rt_fwd = rt_val_r;
    if (bus.mem_reg_write && (bus.mem_write_addr != 5'd0) &&
        (bus.mem_write_addr == rt_addr_r))
      rt_fwd = bus.mem_alu_result;
    else if (bus.wb_reg_write && (bus.wb_write_addr != 5'd0) &&
             (bus.wb_write_addr == rt_addr_r))
      rt_fwd = bus.wb_write_data;
  end
`else
  assign rs_fwd = rs_val_r;
  assign rt_fwd = rt_val_r;
`endif

  assign bus.stall          = stall_int;
  assign bus.ex_op1         = rs_fwd;
  assign bus.ex_op2         = alu_src_r ? imm_r : rt_fwd;
  assign bus.ex_store_data  = rt_fwd;
  assign bus.ex_alu_control = alu_control_r;
  assign bus.ex_write_addr  = write_addr_r;
  assign bus.ex_valid       = valid_r;
  assign bus.ex_reg_write   = reg_write_r;
  assign bus.ex_mem_read    = mem_read_r;
  assign bus.ex_mem_write   = mem_write_r;
  assign bus.ex_mem_to_reg  = mem_to_reg_r;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: vector table for single-instruction capture plus
// hand sequences for reset, load-use, flush+stall, $0 guard and the hazard path.
module tb_id_ex_stage;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   total = 0;
  int   passed = 0;

  id_ex_stage_if #(.B(32)) bus();
  id_ex_stage #(.B(32)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));

  always #5 clk = ~clk;

  typedef struct packed {
    logic        valid;
    logic [31:0] rs_d, rt_d, imm;
    logic [4:0]  rs, rt, rd;
    logic [3:0]  ctl;
    logic        src, dst, rw, mr, mw, m2r, flush;
    logic        wbw;
    logic [4:0]  wba;
    logic [31:0] wbd;
    logic        chk_data;
    logic [31:0] e_op1, e_op2, e_st;
    logic [4:0]  e_wa;
    logic        e_v, e_rw, e_mr, e_mw, e_m2r;
  } vec_t;

  vec_t vecs [10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic set_id(input logic v, input logic [31:0] rsd, input logic [31:0] rtd,
                        input logic [31:0] im, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] rd, input logic [3:0] ctl, input logic src,
                        input logic dst, input logic rw, input logic mr, input logic mw,
                        input logic m2r);
    bus.id_valid = v;       bus.id_rs_data = rsd;   bus.id_rt_data = rtd;
    bus.id_imm = im;        bus.id_rs_addr = rs;    bus.id_rt_addr = rt;
    bus.id_rd_addr = rd;    bus.id_alu_control = ctl;
    bus.id_alu_src = src;   bus.id_reg_dst = dst;   bus.id_reg_write = rw;
    bus.id_mem_read = mr;   bus.id_mem_write = mw;  bus.id_mem_to_reg = m2r;
  endtask

  task automatic quiet_fb();
    bus.mem_reg_write = 1'b0; bus.mem_write_addr = 5'd0; bus.mem_alu_result = 32'h0;
    bus.wb_reg_write = 1'b0;  bus.wb_write_addr = 5'd0;  bus.wb_write_data = 32'h0;
    bus.flush = 1'b0;
  endtask

  task automatic idle();
    set_id(1'b0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic chk_ctrl(input string n, input logic v, input logic rw, input logic mr,
                          input logic mw, input logic m2r);
    chk({n, "_valid"},      32'(bus.ex_valid),      32'(v));
    chk({n, "_reg_write"},  32'(bus.ex_reg_write),  32'(rw));
    chk({n, "_mem_read"},   32'(bus.ex_mem_read),   32'(mr));
    chk({n, "_mem_write"},  32'(bus.ex_mem_write),  32'(mw));
    chk({n, "_mem_to_reg"}, 32'(bus.ex_mem_to_reg), 32'(m2r));
  endtask

  initial begin
    //          v  rs_d           rt_d           imm            rs  rt  rd  ctl  src dst rw mr mw m2r fl  wbw wba wbd           chk e_op1          e_op2          e_st           e_wa v  rw mr mw m2r
    vecs[0] = '{1, 32'h10,        32'h20,        32'h0,         5'd1, 5'd2, 5'd3, 4'h2, 0,1,1,0,0,0,0, 0,5'd0, 32'h0,       1, 32'h10,        32'h20,        32'h20,        5'd3, 1,1,0,0,0};
    vecs[1] = '{1, 32'h100,       32'h7,         32'hFFFFFFFC,  5'd5, 5'd6, 5'd0, 4'h2, 1,0,1,0,0,0,0, 0,5'd0, 32'h0,       1, 32'h100,       32'hFFFFFFFC,  32'h7,         5'd6, 1,1,0,0,0};
    vecs[2] = '{1, 32'h2000,      32'h55,        32'h4,         5'd7, 5'd9, 5'd0, 4'h2, 1,0,1,1,0,1,0, 0,5'd0, 32'h0,       1, 32'h2000,      32'h4,         32'h55,        5'd9, 1,1,1,0,1};
    vecs[3] = '{1, 32'h3000,      32'hCAFE,      32'h8,         5'd10,5'd11,5'd0, 4'h2, 1,0,0,0,1,0,0, 0,5'd0, 32'h0,       1, 32'h3000,      32'h8,         32'hCAFE,      5'd11,1,0,0,1,0};
    vecs[4] = '{1, 32'hAAAA,      32'h1313,      32'h0,         5'd12,5'd13,5'd14,4'h6, 0,1,1,0,0,0,0, 1,5'd12,32'h5555,    1, 32'h5555,      32'h1313,      32'h1313,      5'd14,1,1,0,0,0};
    vecs[5] = '{1, 32'h0,         32'hE,         32'h0,         5'd0, 5'd14,5'd15,4'h1, 0,1,1,0,0,0,0, 1,5'd0, 32'h9999,    1, 32'h0,         32'hE,         32'hE,         5'd15,1,1,0,0,0};
    vecs[6] = '{0, 32'h1,         32'h2,         32'h3,         5'd1, 5'd2, 5'd3, 4'h2, 0,1,1,1,1,1,0, 0,5'd0, 32'h0,       0, 32'h0,         32'h0,         32'h0,         5'd0, 0,0,0,0,0};
    vecs[7] = '{1, 32'h3000,      32'hCAFE,      32'h8,         5'd10,5'd11,5'd0, 4'h2, 1,0,0,0,1,0,1, 0,5'd0, 32'h0,       0, 32'h0,         32'h0,         32'h0,         5'd0, 0,0,0,0,0};
    vecs[8] = '{1, 32'h1,         32'hABCD,      32'h0,         5'd16,5'd15,5'd17,4'hF, 0,1,1,0,0,0,0, 1,5'd15,32'hBEEF,    1, 32'h1,         32'hBEEF,      32'hBEEF,      5'd17,1,1,0,0,0};
    vecs[9] = '{1, 32'h77,        32'h88,        32'h0,         5'd18,5'd19,5'd20,4'h3, 0,1,1,0,0,0,0, 0,5'd18,32'h1234,    1, 32'h77,        32'h88,        32'h88,        5'd20,1,1,0,0,0};

    // Reset with arbitrary inputs: everything observable must read zero.
    for (int i = 0; i < 4; i++) begin
      set_id(1'b1, $urandom, $urandom, $urandom, 5'($urandom), 5'($urandom), 5'($urandom),
             4'($urandom), 1'($urandom), 1'($urandom), 1'b1, 1'b1, 1'b1, 1'b1);
      bus.mem_reg_write = 1'b1; bus.mem_write_addr = 5'($urandom); bus.mem_alu_result = $urandom;
      bus.wb_reg_write = 1'b1;  bus.wb_write_addr = 5'($urandom);  bus.wb_write_data = $urandom;
      bus.flush = 1'($urandom);
      #7;
      chk($sformatf("rst%0d_outs", i),
          bus.ex_op1 | bus.ex_op2 | bus.ex_store_data |
          {28'h0, bus.ex_alu_control} | {27'h0, bus.ex_write_addr}, 32'h0);
      chk_ctrl($sformatf("rst%0d", i), 0, 0, 0, 0, 0);
      chk($sformatf("rst%0d_stall", i), 32'(bus.stall), 32'h0);
    end
    quiet_fb();
    set_id(1'b1, 32'h5, 32'h0, 32'h0, 5'd1, 5'd2, 5'd3, 4'h2, 0, 1, 1, 0, 0, 0);
    @(negedge clk);
    reset_n = 1'b1;
    tick();
    chk("rst_release_op1", bus.ex_op1, 32'h5);
    chk("rst_release_valid", 32'(bus.ex_valid), 32'h1);

    // Vector table: each vector is preceded by a bubble so no hazard is pending.
    for (int i = 0; i < 10; i++) begin
      idle(); quiet_fb();
      tick();
      set_id(vecs[i].valid, vecs[i].rs_d, vecs[i].rt_d, vecs[i].imm, vecs[i].rs, vecs[i].rt,
             vecs[i].rd, vecs[i].ctl, vecs[i].src, vecs[i].dst, vecs[i].rw, vecs[i].mr,
             vecs[i].mw, vecs[i].m2r);
      bus.flush = vecs[i].flush;
      bus.wb_reg_write = vecs[i].wbw; bus.wb_write_addr = vecs[i].wba; bus.wb_write_data = vecs[i].wbd;
      #1;
      chk($sformatf("v%0d_stall", i), 32'(bus.stall), 32'h0);
      tick();
      quiet_fb(); idle();
      #1;
      if (vecs[i].chk_data) begin
        chk($sformatf("v%0d_op1", i), bus.ex_op1, vecs[i].e_op1);
        chk($sformatf("v%0d_op2", i), bus.ex_op2, vecs[i].e_op2);
        chk($sformatf("v%0d_store", i), bus.ex_store_data, vecs[i].e_st);
        chk($sformatf("v%0d_waddr", i), 32'(bus.ex_write_addr), 32'(vecs[i].e_wa));
        chk($sformatf("v%0d_aluctl", i), 32'(bus.ex_alu_control), 32'(vecs[i].ctl));
      end
      chk_ctrl($sformatf("v%0d", i), vecs[i].e_v, vecs[i].e_rw, vecs[i].e_mr, vecs[i].e_mw, vecs[i].e_m2r);
    end

    // Load-use: lw $8 in EX, add using rt=$8 in ID.
    idle(); quiet_fb(); tick();
    set_id(1'b1, 32'h100, 32'h0, 32'h4, 5'd1, 5'd8, 5'd0, 4'h2, 1, 0, 1, 1, 0, 1);
    tick();
    set_id(1'b1, 32'h1, 32'h2, 32'h0, 5'd1, 5'd8, 5'd9, 4'h2, 0, 1, 1, 0, 0, 0);
    #1;
    chk("lu_stall", 32'(bus.stall), 32'h1);
    tick();
    chk_ctrl("lu_bubble", 0, 0, 0, 0, 0);
    chk("lu_stall_release", 32'(bus.stall), 32'h0);

    // Flush coinciding with load-use: exactly one bubble.
    idle(); tick();
    set_id(1'b1, 32'h100, 32'h0, 32'h4, 5'd1, 5'd8, 5'd0, 4'h2, 1, 0, 1, 1, 0, 1);
    tick();
    set_id(1'b1, 32'h0, 32'h9, 32'h0, 5'd8, 5'd2, 5'd0, 4'h2, 1, 0, 0, 0, 1, 0);
    bus.flush = 1'b1;
    #1;
    chk("fs_stall", 32'(bus.stall), 32'h1);
    tick();
    bus.flush = 1'b0;
    #1;
    chk_ctrl("fs_bubble", 0, 0, 0, 0, 0);
    chk("fs_stall_after", 32'(bus.stall), 32'h0);
    tick();
    chk_ctrl("fs_next", 1, 0, 0, 1, 0);

    // $0 must never pick up a MEM or WB value.
    set_id(1'b1, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0, 4'h2, 0, 0, 0, 0, 0, 0);
    tick();
    idle();
    bus.mem_reg_write = 1'b1; bus.mem_write_addr = 5'd0; bus.mem_alu_result = 32'hFFFF;
    bus.wb_reg_write = 1'b1;  bus.wb_write_addr = 5'd0;  bus.wb_write_data = 32'h9999;
    #1;
    chk("zero_op1", bus.ex_op1, 32'h0);
    chk("zero_store", bus.ex_store_data, 32'h0);
    quiet_fb();

`ifdef FORWARDING_EN
    tick();
    set_id(1'b1, 32'h333, 32'h444, 32'h0, 5'd3, 5'd4, 5'd5, 4'h2, 0, 1, 1, 0, 0, 0);
    tick();
    idle();
    bus.mem_reg_write = 1'b1; bus.mem_write_addr = 5'd3; bus.mem_alu_result = 32'hDEAD;
    bus.wb_reg_write = 1'b1;  bus.wb_write_addr = 5'd3;  bus.wb_write_data = 32'h1111;
    #1;
    chk("fwd_mem_prio", bus.ex_op1, 32'hDEAD);
    chk("fwd_rt_untouched", bus.ex_op2, 32'h444);
    bus.mem_reg_write = 1'b0;
    #1;
    chk("fwd_wb_op1", bus.ex_op1, 32'h1111);
    bus.wb_write_addr = 5'd4; bus.wb_write_data = 32'h4444;
    #1;
    chk("fwd_wb_store", bus.ex_store_data, 32'h4444);
    chk("fwd_wb_op2", bus.ex_op2, 32'h4444);
    chk("fwd_none_op1", bus.ex_op1, 32'h333);
    quiet_fb();
`else
    tick();
    set_id(1'b1, 32'h1, 32'h2, 32'h0, 5'd1, 5'd2, 5'd4, 4'h2, 0, 1, 1, 0, 0, 0);
    tick();
    set_id(1'b1, 32'h44, 32'h55, 32'h0, 5'd4, 5'd5, 5'd6, 4'h2, 0, 1, 1, 0, 0, 0);
    #1;
    chk("raw_stall_ex", 32'(bus.stall), 32'h1);
    tick();
    chk("raw_bubble_valid", 32'(bus.ex_valid), 32'h0);
    bus.mem_reg_write = 1'b1; bus.mem_write_addr = 5'd4; bus.mem_alu_result = 32'h4444;
    #1;
    chk("raw_stall_mem", 32'(bus.stall), 32'h1);
    tick();
    bus.mem_reg_write = 1'b0;
    bus.wb_reg_write = 1'b1; bus.wb_write_addr = 5'd4; bus.wb_write_data = 32'h4444;
    #1;
    chk("raw_stall_wb", 32'(bus.stall), 32'h0);
    tick();
    quiet_fb(); idle();
    #1;
    chk("raw_bypass_op1", bus.ex_op1, 32'h4444);
    chk("raw_bypass_valid", 32'(bus.ex_valid), 32'h1);
`endif

    // Asynchronous reset mid-operation discards the in-flight instruction.
    set_id(1'b1, 32'h77, 32'h0, 32'h0, 5'd1, 5'd2, 5'd3, 4'h2, 0, 1, 1, 0, 0, 0);
    tick();
    #1 reset_n = 1'b0;
    #1;
    chk("midrst_op1", bus.ex_op1, 32'h0);
    chk_ctrl("midrst", 0, 0, 0, 0, 0);
    @(negedge clk);
    reset_n = 1'b1;
    set_id(1'b1, 32'h5, 32'h0, 32'h0, 5'd1, 5'd2, 5'd3, 4'h2, 0, 1, 1, 0, 0, 0);
    tick();
    chk("midrst_recapture", bus.ex_op1, 32'h5);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
